// File: rtl/noc_flit_pkg.sv
// Shared flit framing constants and injector state encoding for the NoC edge.
// The router-side head/tail decode uses the same constants, so both ends agree on framing.
package noc_flit_pkg;

  localparam logic [7:0] FLIT_HEAD = 8'hFF;
  localparam logic [7:0] FLIT_TAIL = 8'h00;
  localparam logic [7:0] FLIT_ESC  = 8'h7D;
  localparam logic [7:0] ESC_XOR   = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD,
    ST_BODY,
    ST_ESC2,
    ST_TAIL
  } inj_state_e;

  // A payload byte that could be mistaken for a marker, or for the escape itself.
  function automatic logic needs_esc(input logic [7:0] b);
    return (b == FLIT_HEAD) || (b == FLIT_TAIL) || (b == FLIT_ESC);
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Per-VC downstream credit counter: starts full, spends one per issued flit and
// regains one per returned credit, saturating at the buffer depth.
module credit_counter #(
  parameter int CREDITS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           consume,
  input  logic                           credit,
  output logic [$clog2(CREDITS+1)-1:0]   count,
  output logic                           nonzero
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of its neighbours regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= FULL;
    end else begin
      case ({consume, credit})
        2'b10:   if (count != '0) count <= count - 1'b1;
        2'b01:   if (count != FULL) count <= count + 1'b1;
        default: ;  // idle, or spend and refund in the same cycle
      endcase
    end
  end

  assign nonzero = (count != '0);

endmodule

// File: rtl/flit_injector.sv
// Packet-to-flit transmitter: frames a latched packet as head, byte-stuffed body
// and tail flits, issuing one flit per cycle whenever the packet's VC holds a credit.
module flit_injector
  import noc_flit_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CREDITS = 4,
  parameter int LENW    = $clog2(MAX_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pkt_valid,
  output logic                   pkt_ready,
  input  logic [8*MAX_LEN-1:0]   pkt_data,
  input  logic [LENW-1:0]        pkt_len,
  input  logic                   pkt_vc,
  output logic [7:0]             out_data,
  output logic                   valid_out,
  output logic                   out_vc,
  input  logic [1:0]             credit_in
);

  localparam int IDXW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CW   = $clog2(CREDITS + 1);

  inj_state_e        state;
  logic [7:0]        data_q [MAX_LEN];
  logic [LENW-1:0]   len_q;
  logic              vc_q;
  logic [IDXW-1:0]   idx;

  logic [CW-1:0]     count [2];
  logic [1:0]        nonzero;
  logic              unused_count;
  logic              issue;
  logic              last_byte;
  logic [7:0]        cur_byte;
  logic [7:0]        flit;
  logic [LENW-1:0]   len_clamped;
  logic [LENW-1:0]   idx_plus1;

  for (genvar v = 0; v < 2; v++) begin : g_vc
    credit_counter #(.CREDITS(CREDITS)) u_credit (
      .clk     (clk),
      .reset   (reset),
      .consume (issue && (vc_q == 1'(v))),
      .credit  (credit_in[v]),
      .count   (count[v]),
      .nonzero (nonzero[v])
    );
  end

  // The raw counts are only kept for debug visibility; issue needs just nonzero.
  assign unused_count = ^{count[0], count[1]};

  assign pkt_ready   = (state == ST_IDLE);
  assign issue       = (state != ST_IDLE) && nonzero[vc_q];
  assign cur_byte    = data_q[idx];
  assign idx_plus1   = LENW'(idx) + LENW'(1);
  assign last_byte   = (idx_plus1 == len_q);
  assign len_clamped = (pkt_len > LENW'(MAX_LEN)) ? LENW'(MAX_LEN) : pkt_len;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    flit = FLIT_TAIL;
    case (state)
      ST_HEAD: flit = FLIT_HEAD;
      ST_BODY: flit = needs_esc(cur_byte) ? FLIT_ESC : cur_byte;
      ST_ESC2: flit = cur_byte ^ ESC_XOR;
      default: flit = FLIT_TAIL;
    endcase
  end

  // NOTE: the payload store has no reset; it is only read outside IDLE, and reset
  // forces IDLE, so a stale packet can never be emitted.
  always_ff @(posedge clk) begin
    if (pkt_ready && pkt_valid) begin
      for (int i = 0; i < MAX_LEN; i++) data_q[i] <= pkt_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      vc_q      <= 1'b0;
      idx       <= '0;
      out_data  <= 8'h00;
      valid_out <= 1'b0;
      out_vc    <= 1'b0;
    end else begin
      valid_out <= issue;
      if (issue) begin
        out_data <= flit;
        out_vc   <= vc_q;
      end

      case (state)
        ST_IDLE: if (pkt_valid) begin
          len_q <= len_clamped;
          vc_q  <= pkt_vc;
          idx   <= '0;
          state <= ST_HEAD;
        end
        ST_HEAD: if (issue) state <= (len_q != '0) ? ST_BODY : ST_TAIL;
        ST_BODY: if (issue) begin
          if (needs_esc(cur_byte)) state <= ST_ESC2;
          else if (last_byte)      state <= ST_TAIL;
          else                     idx   <= idx + 1'b1;
        end
        ST_ESC2: if (issue) begin
          if (last_byte) begin
            state <= ST_TAIL;
          end else begin
            idx   <= idx + 1'b1;
            state <= ST_BODY;
          end
        end
        ST_TAIL: if (issue) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flit_injector.sv
// Self-checking bench: a queue-of-flits plus credit-count model predicts every
// output cycle, under directed scenarios and randomized packets and credit returns.
module tb_flit_injector;

  localparam int MAX_LEN = 8;
  localparam int CREDITS = 4;
  localparam int LENW    = $clog2(MAX_LEN + 1);

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 pkt_valid;
  logic                 pkt_ready;
  logic [8*MAX_LEN-1:0] pkt_data;
  logic [LENW-1:0]      pkt_len;
  logic                 pkt_vc;
  logic [7:0]           out_data;
  logic                 valid_out;
  logic                 out_vc;
  logic [1:0]           credit_in;

  always #5 clk = ~clk;

  flit_injector #(.MAX_LEN(MAX_LEN), .CREDITS(CREDITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_data  (pkt_data),
    .pkt_len   (pkt_len),
    .pkt_vc    (pkt_vc),
    .out_data  (out_data),
    .valid_out (valid_out),
    .out_vc    (out_vc),
    .credit_in (credit_in)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: flits still owed for the current packet, credits per VC.
  logic [7:0] fq [$];
  int         cred [2];
  bit         mvc;
  bit         exp_valid;
  logic [7:0] exp_data;
  bit         exp_vc;
  bit         accepted;
  int         mode;          // 0 no credits, 1 echo, 2 vc0 every cycle, 3 random
  logic [1:0] echo_d = 2'b00;

  task automatic model_reset();
    fq.delete();
    cred[0]   = CREDITS;
    cred[1]   = CREDITS;
    mvc       = 1'b0;
    exp_valid = 1'b0;
  endtask

  task automatic load_packet();
    int l;
    l = (int'(pkt_len) > MAX_LEN) ? MAX_LEN : int'(pkt_len);
    fq.push_back(8'hFF);
    for (int i = 0; i < l; i++) begin
      logic [7:0] b;
      b = pkt_data[8*i +: 8];
      if (b == 8'hFF || b == 8'h00 || b == 8'h7D) begin
        fq.push_back(8'h7D);
        fq.push_back(b ^ 8'h20);
      end else begin
        fq.push_back(b);
      end
    end
    fq.push_back(8'h00);
    mvc = pkt_vc;
  endtask

  // One clock: predict the edge, let it happen, then compare just after it.
  task automatic tick(input logic [1:0] extra);
    logic [1:0] cr;
    bit         was_idle;
    case (mode)
      1:       cr = echo_d;
      2:       cr = 2'b01;
      3:       cr = 2'($urandom_range(0, 3));
      default: cr = 2'b00;
    endcase
    cr        = cr | extra;
    credit_in = cr;
    accepted  = 1'b0;
    if (reset) begin
      model_reset();
    end else begin
      was_idle  = (fq.size() == 0);
      exp_valid = 1'b0;
      if (!was_idle && cred[mvc] > 0) begin
        exp_valid = 1'b1;
        exp_data  = fq.pop_front();
        exp_vc    = mvc;
        cred[mvc]--;
      end
      for (int v = 0; v < 2; v++) if (cr[v] && cred[v] < CREDITS) cred[v]++;
      if (was_idle && pkt_valid) begin
        load_packet();
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    echo_d = {valid_out && out_vc, valid_out && !out_vc};
    check("valid_out", valid_out, exp_valid);
    if (exp_valid) begin
      check("out_data", out_data, exp_data);
      check("out_vc", out_vc, exp_vc);
    end
    check("pkt_ready", pkt_ready, (fq.size() == 0));
    credit_in = 2'b00;
  endtask

  task automatic run(input int n, input logic [1:0] extra);
    for (int i = 0; i < n; i++) tick(extra);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_valid", valid_out, 0);
    check("rst_ready", pkt_ready, 1);
    check("rst_data", out_data, 0);
    check("rst_vc", out_vc, 0);
    tick(2'b00);
    reset = 1'b0;
  endtask

  task automatic send(input logic [63:0] d, input int len, input bit vc);
    bit got = 1'b0;
    pkt_data  = d;
    pkt_len   = LENW'(len);
    pkt_vc    = vc;
    pkt_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      tick(2'b00);
      if (accepted) begin
        got = 1'b1;
        break;
      end
    end
    pkt_valid = 1'b0;
    pkt_data  = 64'($urandom());
    if (!got) check("accept_timeout", got, 1);
  endtask

  task automatic wait_idle(input int bound);
    bit done = 1'b0;
    for (int n = 0; n < bound; n++) begin
      if (fq.size() == 0) begin
        done = 1'b1;
        break;
      end
      tick(2'b00);
    end
    if (fq.size() == 0) done = 1'b1;
    check("drain_timeout", done, 1);
  endtask

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 5))
      0:       return 8'hFF;
      1:       return 8'h00;
      2:       return 8'h7D;
      default: return 8'($urandom());
    endcase
  endfunction

  initial begin
    pkt_valid = 1'b0;
    pkt_data  = '0;
    pkt_len   = '0;
    pkt_vc    = 1'b0;
    credit_in = 2'b00;
    mode      = 0;
    do_reset();
    run(2, 2'b00);

    // Basic framing with credits echoed back.
    mode = 1;
    send(64'h0000_0000_0033_2211, 3, 1'b0);
    wait_idle(50);
    // Escaping of marker and escape bytes.
    send(64'h0000_0000_0000_7DFF, 3, 1'b0);
    wait_idle(50);
    // Boundary lengths: empty, and over-long clamped to MAX_LEN.
    send(64'h0, 0, 1'b1);
    wait_idle(50);
    send(64'h8877_6655_4433_2211, 12, 1'b0);
    wait_idle(50);
    run(3, 2'b00);

    // Credit stall on vc0, released by single pulses.
    do_reset();
    mode = 0;
    send(64'h0000_0000_A3A2_A1A0, 4, 1'b0);
    run(6, 2'b00);
    tick(2'b01);
    run(4, 2'b00);
    tick(2'b01);
    run(4, 2'b00);
    // vc1 still has its own credits while vc0 sits at zero.
    send(64'h0000_0000_0000_0055, 1, 1'b1);
    wait_idle(20);
    run(2, 2'b00);

    // Simultaneous spend/refund and saturation at full.
    do_reset();
    mode = 2;
    run(3, 2'b00);
    send(64'h0000_0000_0000_7D7D, 2, 1'b0);
    wait_idle(50);
    run(3, 2'b00);
    mode = 0;
    send(64'h0000_0000_0403_0201, 4, 1'b0);
    run(6, 2'b00);
    tick(2'b01);
    tick(2'b01);
    wait_idle(20);

    // Mid-packet reset, then a clean packet on restored credits.
    do_reset();
    mode = 0;
    send(64'h0000_0055_4433_2211, 5, 1'b0);
    run(2, 2'b00);
    do_reset();
    send(64'h0000_0000_0000_0055, 1, 1'b0);
    wait_idle(20);
    send(64'h0000_0000_0000_0066, 1, 1'b0);
    run(4, 2'b00);
    run(3, 2'b01);
    wait_idle(20);

    // Randomized packets against randomized credit returns.
    do_reset();
    mode = 3;
    for (int p = 0; p < 60; p++) begin
      logic [63:0] d;
      for (int i = 0; i < MAX_LEN; i++) d[8*i +: 8] = rand_byte();
      send(d, $urandom_range(0, 12), 1'($urandom()));
      run($urandom_range(0, 3), 2'b00);
    end
    wait_idle(2000);
    run(3, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
